// File: rtl/ucie_pattern_generator.sv
// ============================================================================
// Module   : ucie_pattern_generator
// Purpose  : 16-lane PRBS23 / per-lane-ID pattern source for mainband training
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ucie_pattern_generator #(
  parameter logic [22:0] SEED_BASE    = 23'h1DBFBC,
  parameter int          PATTERN_LEN  = 4096,
  parameter int          ID_REPS      = 128,
  parameter logic [7:0]  LANE_ID_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_state,
  input  logic        i_start,
  input  logic        i_hold,
  output logic [15:0] o_generated,
  output logic        o_enable_buffer,
  output logic        o_busy,
  output logic        o_done,
  output logic [12:0] o_bit_count
);

  localparam logic [12:0] c_lfsr_len = 13'(PATTERN_LEN);
  localparam logic [12:0] c_id_len   = 13'(16 * ID_REPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LFSR = 2'd1,
    S_ID   = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_enable;
  logic        r_busy;
  logic        r_done;
  logic [12:0] r_bit_count;
  logic [3:0]  r_bit_idx;
  logic [7:0]  r_word_count;

  logic        w_clear;
  logic        w_start;
  logic [12:0] w_limit;
  logic        w_advance;
  logic        w_load_lfsr;
  logic        w_load_id;
  logic [3:0]  w_idx;

  // Busy stays high through the done cycle, so a start there is also ignored.
  assign w_clear     = (i_state == 2'b01);
  assign w_start     = (r_state == S_IDLE) && !r_busy && i_start && i_state[1];
  assign w_limit     = (r_state == S_ID) ? c_id_len : c_lfsr_len;
  assign w_advance   = (r_state != S_IDLE) && !i_hold && (r_bit_count != w_limit);
  assign w_load_lfsr = !w_clear && ((w_start && !i_state[0]) || (w_advance && (r_state == S_LFSR)));
  assign w_load_id   = !w_clear && ((w_start && i_state[0])  || (w_advance && (r_state == S_ID)));
  assign w_idx       = w_start ? 4'd0 : r_bit_idx;

  // Each lane register always holds the next bit to issue in its top bit.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    localparam logic [22:0] c_seed = SEED_BASE ^ {4'(i), 19'b0};
    localparam logic [7:0]  c_id   = LANE_ID_BASE + 8'(i);
    localparam logic [15:0] c_word = {4'b1010, c_id, 4'b1010};

    logic [22:0] r_lfsr;
    logic        r_bit;
    logic        w_fb;

    assign w_fb = r_lfsr[22] ^ r_lfsr[20] ^ r_lfsr[15] ^ r_lfsr[7] ^ r_lfsr[4] ^ r_lfsr[1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lfsr <= c_seed;
        r_bit  <= 1'b0;
      end else if (w_clear) begin
        r_lfsr <= c_seed;
      end else if (w_load_lfsr) begin
        r_bit  <= r_lfsr[22];
        r_lfsr <= {r_lfsr[21:0], w_fb};
      end else if (w_load_id) begin
        r_bit  <= c_word[w_idx];
      end
    end

    assign o_generated[i] = r_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_enable     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bit_count  <= '0;
      r_bit_idx    <= '0;
      r_word_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_clear) begin
        r_state      <= S_IDLE;
        r_enable     <= 1'b0;
        r_busy       <= 1'b0;
        r_bit_count  <= '0;
        r_bit_idx    <= '0;
        r_word_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            if (w_start) begin
              r_state      <= i_state[0] ? S_ID : S_LFSR;
              r_enable     <= 1'b1;
              r_busy       <= 1'b1;
              r_bit_count  <= 13'd1;
              r_bit_idx    <= 4'd1;
              r_word_count <= '0;
            end
          end
          default: begin
            if (i_hold) begin
              r_enable <= 1'b0;
            end else if (r_bit_count == w_limit) begin
              r_enable <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_enable    <= 1'b1;
              r_bit_count <= r_bit_count + 13'd1;
              if (r_state == S_ID) begin
                r_bit_idx <= r_bit_idx + 4'd1;
                if (r_bit_idx == 4'd15) r_word_count <= r_word_count + 8'd1;
              end
            end
          end
        endcase
      end
    end
  end

  assign o_enable_buffer = r_enable;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_bit_count     = r_bit_count;

endmodule

`default_nettype wire

// File: tb/tb_ucie_pattern_generator.sv
// ============================================================================
// Module   : tb_ucie_pattern_generator
// Purpose  : scoreboard bench for the 16-lane training pattern generator
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ucie_pattern_generator;

  localparam logic [22:0] c_seed = 23'h1DBFBC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  i_state = 2'b00;
  logic        i_start = 1'b0;
  logic        i_hold = 1'b0;
  logic [15:0] o_generated;
  logic        o_enable_buffer;
  logic        o_busy;
  logic        o_done;
  logic [12:0] o_bit_count;

  ucie_pattern_generator #(
    .SEED_BASE    (c_seed),
    .PATTERN_LEN  (4096),
    .ID_REPS      (128),
    .LANE_ID_BASE (8'h00)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_state         (i_state),
    .i_start         (i_start),
    .i_hold          (i_hold),
    .o_generated     (o_generated),
    .o_enable_buffer (o_enable_buffer),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_bit_count     (o_bit_count)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_q[$];
  logic [22:0] m_lfsr[16];
  int          en_cnt = 0;
  int          done_cnt = 0;
  logic        diff01 = 1'b0;
  logic        hold_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [22:0] lfsr_step(input logic [22:0] s);
    return {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  function automatic logic [15:0] id_word(input int lane);
    return {4'b1010, 8'(lane), 4'b1010};
  endfunction

  task automatic model_reseed();
    for (int i = 0; i < 16; i++) m_lfsr[i] = c_seed ^ {4'(i), 19'b0};
  endtask

  task automatic push_lfsr(input int n);
    logic [15:0] w;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 16; i++) begin
        w[i]      = m_lfsr[i][22];
        m_lfsr[i] = lfsr_step(m_lfsr[i]);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic push_id(input int reps);
    logic [15:0] w;
    logic [15:0] wd;
    for (int r = 0; r < reps; r++) begin
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) begin
          wd   = id_word(i);
          w[i] = wd[b];
        end
        exp_q.push_back(w);
      end
    end
  endtask

  // Monitor: one scoreboard pop per enabled cycle, plus strobe sanity.
  always @(posedge clk) hold_seen <= i_hold && rst_n;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_seen) check("hold_enable_low", 32'(o_enable_buffer), 32'd0);
      if (o_enable_buffer) begin
        en_cnt++;
        if (o_generated[0] != o_generated[1]) diff01 = 1'b1;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_enable: got word %0h with empty scoreboard", o_generated);
        end else begin
          check("lane_bits", 32'(o_generated), 32'(exp_q.pop_front()));
        end
      end
      if (o_done) begin
        done_cnt++;
        check("done_enable_low", 32'(o_enable_buffer), 32'd0);
        check("done_busy_high", 32'(o_busy), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_burst();
    en_cnt   = 0;
    done_cnt = 0;
    diff01   = 1'b0;
  endtask

  task automatic start_burst(input logic [1:0] st);
    i_state = st;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic do_clear();
    i_state = 2'b01;
    tick();
    model_reseed();
    i_state = 2'b00;
  endtask

  task automatic wait_en(input int target, input string name);
    int k = 0;
    while (en_cnt < target && k < 20000) begin
      tick();
      k++;
    end
    if (en_cnt < target) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d enables required %0d", name, en_cnt, target);
    end
  endtask

  task automatic finish_burst(input string name, input int n);
    int k = 0;
    while (!o_done && k < 20000) begin
      tick();
      k++;
    end
    if (!o_done) begin
      n_total++;
      $display("FAIL %s_done_timeout: got no done required one", name);
    end
    tick();
    check({name, "_bit_count"}, 32'(o_bit_count), 32'(n));
    check({name, "_enabled"}, 32'(en_cnt), 32'(n));
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_after"}, 32'(o_busy), 32'd0);
  endtask

  task automatic check_first_bits(input string name);
    check({name, "_en_first"}, 32'(o_enable_buffer), 32'd1);
    check({name, "_busy_first"}, 32'(o_busy), 32'd1);
    check({name, "_lane0_bit0"}, 32'(o_generated[0]), 32'd0);
    check({name, "_lane8_bit0"}, 32'(o_generated[8]), 32'd1);
  endtask

  initial begin
    model_reseed();
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_generated", 32'(o_generated), 32'd0);
    check("rst_enable", 32'(o_enable_buffer), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_bit_count", 32'(o_bit_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain LFSR burst from the seed
    do_clear();
    new_burst();
    push_lfsr(4096);
    start_burst(2'b10);
    check_first_bits("lfsr1");
    finish_burst("lfsr1", 4096);
    check("lane0_lane1_differ", 32'(diff01), 32'd1);

    // ID burst: 128 words of {1010, id, 1010} per lane, LSB first
    new_burst();
    push_id(128);
    start_burst(2'b11);
    check("id_lane5_bit0", 32'(o_generated[5]), 32'd0);
    tick();
    check("id_lane5_bit1", 32'(o_generated[5]), 32'd1);
    finish_burst("id", 2048);

    // Ten-cycle hold at bit 100
    do_clear();
    new_burst();
    push_lfsr(4096);
    start_burst(2'b10);
    wait_en(100, "hold");
    i_hold = 1'b1;
    repeat (10) tick();
    check("hold_busy", 32'(o_busy), 32'd1);
    check("hold_count_frozen", 32'(o_bit_count), 32'd101);
    i_hold = 1'b0;
    finish_burst("hold", 4096);

    // Abort with CLEAR_LFSR at bit 2000
    do_clear();
    new_burst();
    push_lfsr(4096);
    start_burst(2'b10);
    wait_en(2000, "abort");
    i_state = 2'b01;
    tick();
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_enable", 32'(o_enable_buffer), 32'd0);
    check("abort_bit_count", 32'(o_bit_count), 32'd0);
    i_state = 2'b10;
    repeat (5) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    exp_q.delete();
    model_reseed();

    // Replay from the seed with a stray start mid-burst
    new_burst();
    push_lfsr(4096);
    start_burst(2'b10);
    check_first_bits("replay");
    wait_en(500, "restart");
    start_burst(2'b10);
    finish_burst("replay", 4096);

    // Reset mid-burst, then a fresh burst from the seed
    new_burst();
    push_lfsr(4096);
    start_burst(2'b10);
    wait_en(300, "reset");
    rst_n = 1'b0;
    #1;
    check("midrst_generated", 32'(o_generated), 32'd0);
    check("midrst_enable", 32'(o_enable_buffer), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_bit_count", 32'(o_bit_count), 32'd0);
    exp_q.delete();
    model_reseed();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    new_burst();
    push_lfsr(4096);
    start_burst(2'b10);
    check_first_bits("postrst");
    finish_burst("postrst", 4096);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
